// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces nickel/dime sensors and emits one registered credit (or reject) pulse per coin.
// Credit appears on the edge sampling the DEBOUNCE-th high; a held or double sensor trips JAM until both stay low.
module coin_acceptor #(
  parameter int DEBOUNCE = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       nickel_in,
  input  logic       dime_in,
  input  logic       open,
  output logic       N,
  output logic       D,
  output logic       reject,
  output logic       jam,
  output logic [7:0] coin_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUAL_N  = 3'd1,
    QUAL_D  = 3'd2,
    EMIT    = 3'd3,
    RELEASE = 3'd4,
    JAM     = 3'd5
  } state_t;

  localparam logic [3:0] QUAL_LAST = 4'(DEBOUNCE - 1);
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q;
  logic [3:0] qual_cnt_q;
  logic [7:0] hold_cnt_q;
  logic [7:0] coin_cnt_q;
  logic       n_q;
  logic       d_q;
  logic       rej_q;
  logic       jam_q;

  logic       own_hi;
  logic       oth_hi;
  logic       any_hi;
  logic [7:0] coin_cnt_d;

  // Sensor roles are relative to the coin being qualified.
  always_comb begin
    own_hi     = (state_q == QUAL_D) ? dime_in : nickel_in;
    oth_hi     = (state_q == QUAL_D) ? nickel_in : dime_in;
    any_hi     = nickel_in | dime_in;
    coin_cnt_d = (coin_cnt_q == 8'hFF) ? coin_cnt_q : coin_cnt_q + 8'd1;
  end

  // qual_cnt_q doubles as the consecutive-low counter while in JAM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      qual_cnt_q <= 4'd0;
      hold_cnt_q <= 8'd0;
      coin_cnt_q <= 8'd0;
      n_q        <= 1'b0;
      d_q        <= 1'b0;
      rej_q      <= 1'b0;
      jam_q      <= 1'b0;
    end else begin
      n_q   <= 1'b0;
      d_q   <= 1'b0;
      rej_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (nickel_in && dime_in) begin
            state_q    <= JAM;
            rej_q      <= 1'b1;
            jam_q      <= 1'b1;
            qual_cnt_q <= 4'd0;
          end else if (nickel_in) begin
            state_q    <= QUAL_N;
            qual_cnt_q <= 4'd1;
          end else if (dime_in) begin
            state_q    <= QUAL_D;
            qual_cnt_q <= 4'd1;
          end
        end
        QUAL_N, QUAL_D: begin
          if (oth_hi) begin
            state_q    <= JAM;
            rej_q      <= 1'b1;
            jam_q      <= 1'b1;
            qual_cnt_q <= 4'd0;
          end else if (!own_hi) begin
            state_q    <= IDLE;
            qual_cnt_q <= 4'd0;
          end else if (qual_cnt_q == QUAL_LAST) begin
            state_q    <= EMIT;
            qual_cnt_q <= 4'd0;
            if (open) begin
              rej_q <= 1'b1;
            end else begin
              n_q        <= (state_q == QUAL_N);
              d_q        <= (state_q == QUAL_D);
              coin_cnt_q <= coin_cnt_d;
            end
          end else begin
            qual_cnt_q <= qual_cnt_q + 4'd1;
          end
        end
        EMIT: begin
          state_q    <= RELEASE;
          hold_cnt_q <= 8'd0;
        end
        RELEASE: begin
          if (!any_hi) begin
            state_q <= IDLE;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q    <= JAM;
            rej_q      <= 1'b1;
            jam_q      <= 1'b1;
            qual_cnt_q <= 4'd0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        JAM: begin
          if (any_hi) begin
            qual_cnt_q <= 4'd0;
          end else if (qual_cnt_q == QUAL_LAST) begin
            state_q    <= IDLE;
            jam_q      <= 1'b0;
            qual_cnt_q <= 4'd0;
          end else begin
            qual_cnt_q <= qual_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign N        = n_q;
  assign D        = d_q;
  assign reject   = rej_q;
  assign jam      = jam_q;
  assign coin_cnt = coin_cnt_q;

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive high samples needed to qualify a coin; legal range 2..15.
REQ-002 Parameter MAX_HOLD, default 16: maximum cycles a sensor may stay high after qualification before a jam is declared; legal range DEBOUNCE+1..255.
REQ-003 clk  input  1  single system clock, rising edge active.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 nickel_in  input  1  raw nickel sensor, synchronous to clk.
REQ-006 dime_in  input  1  raw dime sensor, synchronous to clk.
REQ-007 open  input  1  dispense indication from the vending machine FSM.
REQ-008 N  output  1  one-cycle nickel-credit pulse to the vending machine FSM.
REQ-009 D  output  1  one-cycle dime-credit pulse to the vending machine FSM.
REQ-010 reject  output  1  one-cycle coin-returned pulse.
REQ-011 jam  output  1  level; high while in JAM.
REQ-012 coin_cnt  output  8  count of accepted coins.

Function
REQ-013 All outputs SHALL be registered, and the block SHALL use states IDLE, QUAL_N, QUAL_D, EMIT, RELEASE, JAM.
REQ-014 IDLE, exactly one sensor high: go to QUAL_N or QUAL_D with qual_cnt=1; both high: go to JAM; both low: stay.
REQ-015 QUAL_x, own sensor high and other low: increment qual_cnt; own sensor low: return to IDLE silently as a glitch, no output; other sensor high: go to JAM.
REQ-016 The edge that samples the DEBOUNCE-th consecutive high of the qualifying sensor SHALL enter EMIT, with N (nickel) or D (dime) high for exactly that one cycle.
REQ-017 When open=1 on the edge that would enter EMIT, the block SHALL assert reject instead of N/D, leave coin_cnt unchanged, and still enter EMIT.
REQ-018 An accepted coin SHALL increment coin_cnt on the same edge that raises N/D, saturating at 255 with no wrap.
REQ-019 EMIT SHALL last one cycle, then go unconditionally to RELEASE; N, D and reject SHALL never be high together or for more than one cycle.
REQ-020 RELEASE: both sensors low: go to IDLE; otherwise increment hold_cnt (cleared on entering RELEASE); hold_cnt reaching MAX_HOLD: go to JAM.
REQ-021 No new coin SHALL be qualified until RELEASE sees both sensors low, so a held sensor yields exactly one credit.
REQ-022 Entering JAM from any state SHALL pulse reject for one cycle and set jam=1, with jam held high for the whole JAM residency.
REQ-023 JAM exits to IDLE only after DEBOUNCE consecutive cycles with both sensors low, and any sensor high restarts that count; jam SHALL fall on the exit edge.
REQ-024 A maximum of one credit pulse SHALL be produced per qualification, with N-to-N spacing of at least DEBOUNCE+2 cycles.

Reset
REQ-025 rstn=0 SHALL asynchronously force state=IDLE, N=0, D=0, reject=0, jam=0, coin_cnt=0, qual_cnt=0 and hold_cnt=0.
REQ-026 Reset mid-qualification or mid-jam SHALL discard the partial coin with no output pulse; operation resumes on the first edge after rstn deasserts.

Verification (DEBOUNCE=4, MAX_HOLD=16)
REQ-027 nickel_in high 6 cycles, open=0 -> one N pulse on the 4th sampled-high edge, coin_cnt=1, D=0, reject=0.
REQ-028 dime_in high 3 cycles then low -> no N/D/reject, coin_cnt unchanged, state returns to IDLE.
REQ-029 Nickel, then dime, then nickel coins each 5 cycles high with 3-cycle gaps -> pulse sequence N, D, N, coin_cnt=3, giving credit 20 to the vending FSM.
REQ-030 dime_in qualifies while open=1 -> reject pulse only, no D, coin_cnt unchanged.
REQ-031 nickel_in and dime_in rise together -> reject pulse and jam=1; nickel_in held high 30 cycles -> jam stays 1; both low 4 cycles -> jam=0, IDLE.
REQ-032 rstn pulsed low during QUAL_D at qual_cnt=2 -> all outputs 0 immediately; coin_cnt=0 after release, no D pulse.
